mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Multi-cycle data-memory responder: the target end of the memory stage's load/store interface.
- Replaces the single-cycle memory model in the memory stage with fixed-latency behaviour, so the pipeline's stall/done handling can be exercised.
- Byte-addressed, big-endian, 16-bit words. Accesses are aligned word accesses only.
- Holds at most one outstanding request, tracked by a small FSM and latency counter.

Parameters:
- LATENCY, 4, cycles from request cycle to done cycle (legal range 1..15).
- ADDR_BITS, 9, number of byte-address bits decoded. Memory holds 2^(ADDR_BITS-1) words; upper addr bits are ignored.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- rd  in  1  read request.
- wr  in  1  write request.
- addr  in  16  byte address of the request.
- data_in  in  16  write data.
- data_out  out  16  read data, registered. Valid in the done cycle; held until the next done.
- stall  out  1  responder busy; new requests are ignored.
- done  out  1  one-cycle pulse marking completion of the accepted request.
- err  out  1  pulses with done when the accepted request was illegal.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, counter=0.
  - stall=0, done=0, err=0, data_out=16'h0000.
  - All memory words cleared to 0.
  - Reset mid-operation aborts any pending request: no write commit, no done.
- FSM states: IDLE, BUSY, DONE.
- Acceptance: a request is presented in cycle C when (rd|wr)=1 and state is IDLE or DONE. It is sampled at the rising edge ending cycle C, latching addr, data_in, rd, wr and the illegal flag.
- Requests presented while in BUSY are ignored entirely; the initiator must hold or re-present them.
- Transitions:
  - LATENCY=1: accept goes directly to DONE.
  - LATENCY>1: accept goes to BUSY with counter=LATENCY-1.
  - BUSY: counter decrements each cycle; at the edge where counter==1 the state moves to DONE.
  - DONE with a new request: accept it (back-to-back); otherwise go to IDLE.
  - IDLE with no request: stay in IDLE.
- Outputs:
  - stall = (state==BUSY), so stall is high in cycles C+1 .. C+LATENCY-1.
  - done = (state==DONE), high in cycle C+LATENCY only.
- Illegal request: addr[0]=1 (misaligned), or rd&wr both high.
  - Takes the full LATENCY.
  - err=1 with done.
  - No memory write; data_out keeps its previous value.
- Legal read:
  - Word index is addr[ADDR_BITS-1:1].
  - data_out = {mem byte at even addr, byte at addr+1} (big-endian), loaded at the edge entering DONE.
- Legal write:
  - The array is updated at the edge entering DONE; data_out is unchanged.
  - A read accepted back-to-back in the DONE cycle sees the new data.
- Address wrap: bits above ADDR_BITS-1 are ignored, so 16'h0200 aliases 16'h0000 at default ADDR_BITS.
- done and stall are never high in the same cycle; err is never high without done.

Test Plan:
- Reset, then idle 10 cycles -> stall=0, done=0, err=0, data_out=0 throughout. Read of addr 0x0010 -> data_out=0x0000.
- Write 0xBEEF to 0x0010 in cycle 0 (LATENCY=4) -> stall=1 in cycles 1-3, done=1 in cycle 4 only. Read of 0x0010 presented in cycle 4 -> done in cycle 8, data_out=0xBEEF, err=0.
- Read 0x0011 (misaligned), or rd=wr=1 at 0x0010 with data 0x1234 -> done+err=1 at LATENCY, data_out unchanged. A later read of 0x0010 still returns 0xBEEF.
- Write 0x1111 at 0x0020, then a write of 0x2222 at 0x0020 presented during cycles 1-3 (BUSY) and dropped -> read of 0x0020 returns 0x1111.
- Assert rst during cycle 2 of a write of 0x5555 to 0x0030 -> immediately stall=0 and no done. After release, read of 0x0030 returns 0x0000.
- Aliasing at ADDR_BITS=9: write 0xA5A5 to 0x0200 -> read of 0x0000 returns 0xA5A5. Repeat at LATENCY=1: done occurs in the cycle after the request, with stall never asserted.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency, single-outstanding data-memory responder.
// Byte-addressed, big-endian 16-bit words, aligned word accesses only.
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   rd, wr              read / write request strobes
//   addr                byte address (bits above ADDR_BITS-1 ignored)
//   data_in             write data
//   data_out            registered read data, held until the next legal read
//   stall               busy; requests presented now are ignored
//   done                one-cycle completion pulse
//   err                 pulses with done for an illegal request
module mem_responder #(
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned ADDR_BITS = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        stall,
  output logic        done,
  output logic        err
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned IDX_W  = ADDR_BITS - 1;
  localparam int unsigned WORDS  = 1 << IDX_W;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [DATA_W-1:0]  mem [WORDS];

  // Request latched at acceptance
  logic [IDX_W-1:0]   q_idx;
  logic [DATA_W-1:0]  q_data;
  logic               q_rd;
  logic               q_wr;
  logic               q_ill;

  logic               accept_c;
  logic               ill_c;
  logic [IDX_W-1:0]   idx_c;
  logic               commit_c;
  logic [IDX_W-1:0]   c_idx;
  logic [DATA_W-1:0]  c_data;
  logic               c_rd;
  logic               c_wr;
  logic               c_ill;
  logic               unused_addr_hi;

  // High address bits alias by design
  assign unused_addr_hi = ^(addr >> ADDR_BITS);

  // Request decode
  always_comb begin
    accept_c = (rd | wr) && (state != BUSY);
    ill_c    = addr[0] | (rd & wr);
    idx_c    = addr[ADDR_BITS-1:1];
  end

  // Completion happens at the edge entering DONE; with LATENCY=1 that is the
  // acceptance edge itself, so the live request is committed directly.
  always_comb begin
    if (LATENCY == 1) begin
      commit_c = accept_c;
      c_idx    = idx_c;
      c_data   = data_in;
      c_rd     = rd;
      c_wr     = wr;
      c_ill    = ill_c;
    end else begin
      commit_c = (state == BUSY) && (count == CNT_W'(1));
      c_idx    = q_idx;
      c_data   = q_data;
      c_rd     = q_rd;
      c_wr     = q_wr;
      c_ill    = q_ill;
    end
  end

  // FSM, latency counter, memory array and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      stall    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      data_out <= '0;
      q_idx    <= '0;
      q_data   <= '0;
      q_rd     <= 1'b0;
      q_wr     <= 1'b0;
      q_ill    <= 1'b0;
      for (int i = 0; i < int'(WORDS); i++) mem[i] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (accept_c) begin
            q_idx  <= idx_c;
            q_data <= data_in;
            q_rd   <= rd;
            q_wr   <= wr;
            q_ill  <= ill_c;
            if (LATENCY == 1) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= ill_c;
            end else begin
              state <= BUSY;
              count <= CNT_W'(LATENCY - 1);
              stall <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (count == CNT_W'(1)) begin
            state <= DONE;
            count <= '0;
            stall <= 1'b0;
            done  <= 1'b1;
            err   <= q_ill;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          stall <= 1'b0;
        end
      endcase

      // Illegal requests never touch the array or data_out
      if (commit_c && !c_ill) begin
        if (c_wr) mem[c_idx] <= c_data;
        if (c_rd) data_out   <= mem[c_idx];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: DUT 0 at LATENCY=4, DUT 1 at LATENCY=1, both ADDR_BITS=9.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd0, wr0, rd1, wr1;
  logic [15:0] addr0, din0, addr1, din1;
  logic [15:0] dout0, dout1;
  logic        stall0, done0, err0, stall1, done1, err1;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [15:0] model [2][256];
  logic [15:0] dm [2];
  logic [16:0] sb [$];

  always #5 clk = ~clk;

  mem_responder #(.LATENCY(4), .ADDR_BITS(9)) dut0 (
    .clk(clk), .rst(rst), .rd(rd0), .wr(wr0), .addr(addr0), .data_in(din0),
    .data_out(dout0), .stall(stall0), .done(done0), .err(err0)
  );

  mem_responder #(.LATENCY(1), .ADDR_BITS(9)) dut1 (
    .clk(clk), .rst(rst), .rd(rd1), .wr(wr1), .addr(addr1), .data_in(din1),
    .data_out(dout1), .stall(stall1), .done(done1), .err(err1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic r, input logic wv,
                       input logic [15:0] a, input logic [15:0] d);
    if (w == 0) begin rd0 = r; wr0 = wv; addr0 = a; din0 = d; end
    else        begin rd1 = r; wr1 = wv; addr1 = a; din1 = d; end
  endtask

  function automatic logic get_stall(input int w); return (w == 0) ? stall0 : stall1; endfunction
  function automatic logic get_done(input int w);  return (w == 0) ? done0  : done1;  endfunction
  function automatic logic get_err(input int w);   return (w == 0) ? err0   : err1;   endfunction
  function automatic logic [15:0] get_dout(input int w); return (w == 0) ? dout0 : dout1; endfunction

  task automatic clear_models();
    for (int i = 0; i < 256; i++) begin
      model[0][i] = '0;
      model[1][i] = '0;
    end
    dm[0] = '0;
    dm[1] = '0;
  endtask

  // Present one request in the current cycle, walk to its done cycle and
  // return while still inside it (so the next call is back-to-back).
  // With intrude set, a write of 0x2222 is held throughout the busy cycles.
  task automatic access(input int w, input logic r, input logic wv,
                        input logic [15:0] a, input logic [15:0] d, input logic intrude);
    int          lat;
    logic        ill;
    logic [7:0]  idx;
    logic [16:0] exp;
    lat = (w == 0) ? 4 : 1;
    ill = a[0] | (r & wv);
    idx = a[8:1];
    if (!ill && wv) model[w][idx] = d;
    if (!ill && r)  dm[w] = model[w][idx];
    sb.push_back({ill, dm[w]});
    drive(w, r, wv, a, d);
    for (int k = 1; k <= lat; k++) begin
      tick();
      if (intrude && k < lat) drive(w, 1'b0, 1'b1, a, 16'h2222);
      else                    drive(w, 1'b0, 1'b0, 16'h0, 16'h0);
      check($sformatf("stall[%0d] k=%0d", w, k), 32'(get_stall(w)), 32'(k < lat));
      check($sformatf("done[%0d] k=%0d", w, k),  32'(get_done(w)),  32'(k == lat));
      if (k < lat) check($sformatf("err_early[%0d] k=%0d", w, k), 32'(get_err(w)), 32'(0));
    end
    exp = sb.pop_front();
    check($sformatf("err[%0d] a=%h", w, a),      32'(get_err(w)),  32'(exp[16]));
    check($sformatf("data_out[%0d] a=%h", w, a), 32'(get_dout(w)), 32'(exp[15:0]));
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    clear_models();
    repeat (2) @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      check("rst_stall", 32'(get_stall(w)), 32'(0));
      check("rst_done",  32'(get_done(w)),  32'(0));
      check("rst_err",   32'(get_err(w)),   32'(0));
      check("rst_dout",  32'(get_dout(w)),  32'(0));
    end
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      for (int w = 0; w < 2; w++) begin
        check("idle_stall", 32'(get_stall(w)), 32'(0));
        check("idle_done",  32'(get_done(w)),  32'(0));
        check("idle_err",   32'(get_err(w)),   32'(0));
        check("idle_dout",  32'(get_dout(w)),  32'(0));
      end
    end

    // Read of cleared memory, then write + back-to-back read
    access(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    tick();
    access(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
    access(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    tick();

    // Illegal requests: misaligned read, rd&wr together
    access(0, 1'b1, 1'b0, 16'h0011, 16'h0000, 1'b0);
    access(0, 1'b1, 1'b1, 16'h0010, 16'h1234, 1'b0);
    tick();
    access(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    tick();

    // Write presented while busy is dropped
    access(0, 1'b0, 1'b1, 16'h0020, 16'h1111, 1'b1);
    tick();
    access(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
    tick();

    // Reset in cycle 2 of a write aborts it
    drive(0, 1'b0, 1'b1, 16'h0030, 16'h5555);
    tick();
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    check("pre_rst_stall", 32'(stall0), 32'(1));
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_stall", 32'(stall0), 32'(0));
    check("mid_rst_done",  32'(done0),  32'(0));
    clear_models();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_done",  32'(done0),  32'(0));
      check("post_rst_stall", 32'(stall0), 32'(0));
    end
    access(0, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0);
    access(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    tick();

    // Address aliasing above ADDR_BITS
    access(0, 1'b0, 1'b1, 16'h0200, 16'hA5A5, 1'b0);
    tick();
    access(0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    tick();

    // LATENCY=1 instance: aliasing, back-to-back, illegal
    access(1, 1'b0, 1'b1, 16'h0200, 16'hA5A5, 1'b0);
    access(1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    tick();
    access(1, 1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0);
    access(1, 1'b0, 1'b1, 16'h0100, 16'h3C3C, 1'b0);
    access(1, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0);
    tick();
    check("final_done1", 32'(done1), 32'(0));
    check("final_done0", 32'(done0), 32'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
